// File: rtl/ra8_fetch_pkg.sv
// Shared definitions for the ra8 instruction fetch stage: FSM state codes,
// instruction length constants and the opcode[7:6] length encodings.
package ra8_fetch_pkg;

    // Fetch FSM states; HOLD is the only state without a memory request.
    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        FETCH_B1 = 2'd1,
        FETCH_B2 = 2'd2,
        HOLD     = 2'd3
    } fetch_state_t;

    // Instruction length in bytes as presented on ir_len.
    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    // opcode[7:6] length encodings; the reserved code is fetched as 1 byte.
    localparam logic [1:0] ENC_LEN_1 = 2'b00;
    localparam logic [1:0] ENC_LEN_2 = 2'b01;
    localparam logic [1:0] ENC_LEN_3 = 2'b10;
    localparam logic [1:0] ENC_RSVD  = 2'b11;

    // Map the two length bits of an opcode to a byte count.
    function automatic logic [1:0] len_from_enc(input logic [1:0] enc);
        logic [1:0] len;
        case (enc)
            ENC_LEN_1: len = LEN_1;
            ENC_LEN_2: len = LEN_2;
            ENC_LEN_3: len = LEN_3;
            default:   len = LEN_1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: program memory read port plus the instruction
// hand-off to the decoder.
//
// Handshakes:
//   memory  : mem_req is held high until a one-cycle mem_ack pulse completes the
//             read; mem_rdata is only meaningful in the mem_ack cycle, and mem_ack
//             while mem_req is low carries no meaning.
//   decoder : ir_valid/ir_ready; an instruction transfers on a rising edge where
//             both are high. While ir_valid is high and ir_ready low, all ir_*
//             fields hold stable; ir_valid never drops without a transfer except
//             on flush or reset.
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir_opcode;
    logic [DATA_W-1:0] ir_op1;
    logic [DATA_W-1:0] ir_op2;
    logic [1:0]        ir_len;

    // Fetch unit side.
    modport master (
        output mem_req, mem_addr, ir_valid, ir_opcode, ir_op1, ir_op2, ir_len,
        input  mem_rdata, mem_ack, ir_ready
    );

    // Memory / decoder side.
    modport slave (
        input  mem_req, mem_addr, ir_valid, ir_opcode, ir_op1, ir_op2, ir_len,
        output mem_rdata, mem_ack, ir_ready
    );
endinterface

// File: rtl/instr_len_decode.sv
// Combinational opcode -> instruction length decode. Kept as its own module so
// the decoder stage can reuse exactly the same length rules.
module instr_len_decode
    import ra8_fetch_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] opcode,
    output logic [1:0]        len
);

    // Only the top two bits select the length.
    logic unused_low_bits;
    assign unused_low_bits = ^opcode[DATA_W-3:0];

    // Length from opcode[7:6].
    always_comb begin
        len = len_from_enc(opcode[DATA_W-1 -: 2]);
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Reads 1-3 instruction bytes from program memory at
// pc_i, pulses pc_inc once per byte consumed, and presents the assembled
// instruction to the decoder with a valid/ready handshake.
// Optional feature macro: FETCH_TIMEOUT_EN (sticky fetch_err after TIMEOUT_CYC
// cycles of an unanswered memory request).
module instr_fetch
    import ra8_fetch_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               pc_inc,
    input  logic               flush,
    instr_fetch_if.master      bus,
    output logic               fetch_err,
    output fetch_state_t       state_dbg
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] opcode_q, op1_q, op2_q;
    logic              cap_op, cap_b1, cap_b2, clr_ops;
    logic              req, ack_take;
    logic [1:0]        rdata_len, cur_len;

    // Length of the byte arriving now (for the opcode) and of the held opcode.
    instr_len_decode #(.DATA_W(DATA_W)) u_len_rdata (
        .opcode (bus.mem_rdata),
        .len    (rdata_len)
    );

    instr_len_decode #(.DATA_W(DATA_W)) u_len_ir (
        .opcode (opcode_q),
        .len    (cur_len)
    );

    // Request/accept terms; the request is forced low while reset is asserted.
    always_comb begin
        req      = (state_q != HOLD) && reset_n;
        ack_take = req && bus.mem_ack && !flush;
    end

    // Next-state and per-cycle controls; flush overrides every other action.
    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        cap_op  = 1'b0;
        cap_b1  = 1'b0;
        cap_b2  = 1'b0;
        clr_ops = 1'b0;
        if (flush) begin
            state_d = FETCH_OP;
            clr_ops = 1'b1;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (ack_take) begin
                        pc_inc  = 1'b1;
                        cap_op  = 1'b1;
                        state_d = (rdata_len == LEN_1) ? HOLD : FETCH_B1;
                    end
                end
                FETCH_B1: begin
                    if (ack_take) begin
                        pc_inc  = 1'b1;
                        cap_b1  = 1'b1;
                        state_d = (cur_len == LEN_2) ? HOLD : FETCH_B2;
                    end
                end
                FETCH_B2: begin
                    if (ack_take) begin
                        pc_inc  = 1'b1;
                        cap_b2  = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ir_ready) begin
                        state_d = FETCH_OP;
                        clr_ops = 1'b1;
                    end
                end
                default: begin
                    state_d = FETCH_OP;
                    clr_ops = 1'b1;
                end
            endcase
        end
    end

    // State register and instruction byte capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH_OP;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            state_q <= state_d;
            if (cap_op) opcode_q <= bus.mem_rdata;
            if (cap_b1) op1_q    <= bus.mem_rdata;
            if (cap_b2) op2_q    <= bus.mem_rdata;
            if (clr_ops) begin
                op1_q <= '0;
                op2_q <= '0;
            end
        end
    end

    assign bus.mem_req   = req;
    assign bus.mem_addr  = pc_i;
    assign bus.ir_valid  = (state_q == HOLD);
    assign bus.ir_opcode = opcode_q;
    assign bus.ir_op1    = op1_q;
    assign bus.ir_op2    = op2_q;
    assign bus.ir_len    = cur_len;
    assign state_dbg     = state_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    // Count unanswered request cycles; flag sticks once the limit is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (flush || (req && bus.mem_ack)) begin
            wait_cnt_q <= '0;
        end else if (req) begin
            if (wait_cnt_q != CNT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_cnt_q == CNT_MAX - 1'b1) err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign fetch_err          = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural PC, byte-wide program memory
// with programmable ack delay, and hand-computed expected values.
module tb_instr_fetch;
    import ra8_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [15:0]  pc = 16'h0000;
    logic         pc_inc;
    logic         flush;
    logic [15:0]  flush_pc;
    logic         fetch_err;
    fetch_state_t state_dbg;

    instr_fetch_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    instr_fetch #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYC(15)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc_i      (pc),
        .pc_inc    (pc_inc),
        .flush     (flush),
        .bus       (bus),
        .fetch_err (fetch_err),
        .state_dbg (state_dbg)
    );

    // clock / PC model
    always #5 clk = ~clk;

    int pulses = 0;
    always @(posedge clk) begin
        if (flush) pc <= flush_pc;
        else if (pc_inc) pc <= pc + 16'd1;
        if (pc_inc) pulses <= pulses + 1;
    end

    logic [7:0] mem [0:255];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit auto_ack = 1'b0;
    int base;
    logic exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle with the auto-responding memory; inputs change at negedge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        flush = 1'b0;
        if (auto_ack && bus.mem_req) begin
            if (wait_cnt == ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr[7:0]];
                wait_cnt      = 0;
                last_ack_cyc  = cyc;
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end
        #1;
    endtask

    // One cycle with manually driven ack/data/flush.
    task automatic man_cycle(input logic a, input logic [7:0] d, input logic f, input logic [15:0] fpc);
        @(negedge clk);
        cyc++;
        bus.mem_ack   = a;
        bus.mem_rdata = d;
        flush         = f;
        flush_pc      = fpc;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (bus.ir_valid) break;
            tick();
        end
        check({tag, "_valid"}, 32'(bus.ir_valid), 32'd1);
    endtask

    task automatic accept();
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        check("acc_valid_drop", 32'(bus.ir_valid), 32'd0);
        check("acc_req_rise", 32'(bus.mem_req), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h05;
        mem[8'h01] = 8'h80; mem[8'h02] = 8'h34; mem[8'h03] = 8'h12;
        mem[8'h04] = 8'h41; mem[8'h05] = 8'h99;
        mem[8'h06] = 8'hC7;
        mem[8'hF0] = 8'h01;
        reset_n = 1'b0; flush = 1'b0; flush_pc = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.ir_ready = 1'b0;

        // reset state
        #12;
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_len", 32'(bus.ir_len), 32'd1);
        check("rst_opcode", 32'(bus.ir_opcode), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(FETCH_OP));
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_req", 32'(bus.mem_req), 32'd1);
        check("rel_addr", 32'(bus.mem_addr), 32'h0000);

        // 1-byte instruction, immediate ack
        auto_ack = 1'b1; ack_delay = 0; base = pulses;
        tick();
        check("b1_pcinc", 32'(pc_inc), 32'd1);
        wait_valid("one");
        check("one_lat", 32'(cyc - last_ack_cyc), 32'd1);
        check("one_opc", 32'(bus.ir_opcode), 32'h05);
        check("one_len", 32'(bus.ir_len), 32'd1);
        check("one_op1", 32'(bus.ir_op1), 32'd0);
        check("one_op2", 32'(bus.ir_op2), 32'd0);
        check("one_pulses", 32'(pulses - base), 32'd1);

        // 3-byte instruction with 2-cycle ack delay
        ack_delay = 2; base = pulses;
        accept();
        wait_valid("three");
        check("three_lat", 32'(cyc - last_ack_cyc), 32'd1);
        check("three_opc", 32'(bus.ir_opcode), 32'h80);
        check("three_op1", 32'(bus.ir_op1), 32'h34);
        check("three_op2", 32'(bus.ir_op2), 32'h12);
        check("three_len", 32'(bus.ir_len), 32'd3);
        check("three_pulses", 32'(pulses - base), 32'd3);
        check("three_pc", 32'(pc), 32'h0004);

        // backpressure: decoder stalls 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_req", 32'(bus.mem_req), 32'd0);
            check("bp_pcinc", 32'(pc_inc), 32'd0);
            check("bp_valid", 32'(bus.ir_valid), 32'd1);
            check("bp_opc", 32'({bus.ir_opcode, bus.ir_op1, bus.ir_op2}), 32'h803412);
        end

        // 2-byte then reserved-encoding instruction
        ack_delay = 1;
        accept();
        wait_valid("two");
        check("two_opc", 32'(bus.ir_opcode), 32'h41);
        check("two_op1", 32'(bus.ir_op1), 32'h99);
        check("two_op2", 32'(bus.ir_op2), 32'd0);
        check("two_len", 32'(bus.ir_len), 32'd2);
        ack_delay = 0;
        accept();
        wait_valid("rsvd");
        check("rsvd_opc", 32'(bus.ir_opcode), 32'hC7);
        check("rsvd_len", 32'(bus.ir_len), 32'd1);
        check("rsvd_op1", 32'(bus.ir_op1), 32'd0);

        // flush coinciding with operand ack in a 2-byte fetch
        auto_ack = 1'b0;
        accept();
        check("fl_addr0", 32'(bus.mem_addr), 32'h0007);
        base = pulses;
        man_cycle(1'b1, 8'h42, 1'b0, 16'h0000);
        check("fl_opc_pcinc", 32'(pc_inc), 32'd1);
        man_cycle(1'b1, 8'h55, 1'b1, 16'h00F0);
        check("fl_pcinc", 32'(pc_inc), 32'd0);
        man_cycle(1'b0, 8'h00, 1'b0, 16'h0000);
        check("fl_valid", 32'(bus.ir_valid), 32'd0);
        check("fl_state", 32'(state_dbg), 32'(FETCH_OP));
        check("fl_req", 32'(bus.mem_req), 32'd1);
        check("fl_addr", 32'(bus.mem_addr), 32'h00F0);
        check("fl_op1", 32'(bus.ir_op1), 32'd0);
        check("fl_pulses", 32'(pulses - base), 32'd1);
        auto_ack = 1'b1;
        wait_valid("refetch");
        check("refetch_opc", 32'(bus.ir_opcode), 32'h01);
        check("refetch_len", 32'(bus.ir_len), 32'd1);

        // asynchronous reset in the middle of FETCH_B1
        auto_ack = 1'b0;
        accept();
        man_cycle(1'b1, 8'h80, 1'b0, 16'h0000);
        man_cycle(1'b0, 8'h00, 1'b0, 16'h0000);
        check("mid_state", 32'(state_dbg), 32'(FETCH_B1));
        #2 reset_n = 1'b0;
        #1;
        check("ar_req", 32'(bus.mem_req), 32'd0);
        check("ar_pcinc", 32'(pc_inc), 32'd0);
        check("ar_valid", 32'(bus.ir_valid), 32'd0);
        check("ar_opc", 32'(bus.ir_opcode), 32'd0);
        check("ar_len", 32'(bus.ir_len), 32'd1);
        check("ar_state", 32'(state_dbg), 32'(FETCH_OP));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ar_restart_addr", 32'(bus.mem_addr), 32'h00F2);
        auto_ack = 1'b1;
        wait_valid("ar_refetch");
        check("ar_refetch_opc", 32'(bus.ir_opcode), 32'h00);

        // withheld ack: timeout flag (when enabled) is sticky
`ifdef FETCH_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        auto_ack = 1'b0;
        accept();
        for (int i = 0; i < 14; i++) tick();
        check("to_err_early", 32'(fetch_err), 32'd0);
        tick();
        check("to_err", 32'(fetch_err), 32'(exp_err));
        check("to_req_held", 32'(bus.mem_req), 32'd1);
        man_cycle(1'b1, 8'h00, 1'b0, 16'h0000);
        tick();
        check("to_err_sticky", 32'(fetch_err), 32'(exp_err));
        check("to_valid", 32'(bus.ir_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
